// File: rtl/seq_gen_pkg.sv
// Shared types and widths for the serial pattern generator.
package seq_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   localparam int W_DEF = 8;
   localparam int IDX_W = 3;
   localparam int REP_W = 4;
   localparam int GAP_W = 4;

endpackage

// File: rtl/seq_gen_cnt.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module seq_gen_cnt #(
   parameter int CW = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          dec_i,
   output logic [CW-1:0] cnt_o,
   output logic          zero_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_gen.sv
// Serializes a latched pattern MSB-first, repeated with optional idle-low gaps.
//   state   | meaning
//   IDLE    | ready for a request; SOUT low
//   SEND    | shifting out bit idx of the latched pattern
//   GAP     | SOUT held low between repetitions
module seq_gen
   import seq_gen_pkg::*;
#(
   parameter int W   = W_DEF,
   parameter int GAP = 1
) (
   input  logic             ck_i,
   input  logic             r_i,
   input  logic [W-1:0]     din_i,
   input  logic [IDX_W-1:0] len_i,
   input  logic [REP_W-1:0] rep_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             sout_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

   state_e           state_q, state_d;
   logic             sout_q, sout_d;
   logic             done_q, done_d;
   logic [W-1:0]     data_q;
   logic [IDX_W-1:0] len_q;
   logic             cap;

   logic             idx_load, idx_dec, idx_zero;
   logic [IDX_W-1:0] idx_val, idx_cnt;
   logic             rep_load, rep_dec, rep_zero;
   logic [REP_W-1:0] rep_cnt_unused;
   logic             gap_load, gap_dec, gap_zero;
   logic [GAP_W-1:0] gap_cnt_unused;

   seq_gen_cnt #(.CW(IDX_W)) u_idx (
      .clk_i(ck_i), .rst_ni(r_i), .load_i(idx_load), .load_val_i(idx_val),
      .dec_i(idx_dec), .cnt_o(idx_cnt), .zero_o(idx_zero)
   );

   seq_gen_cnt #(.CW(REP_W)) u_rep (
      .clk_i(ck_i), .rst_ni(r_i), .load_i(rep_load), .load_val_i(rep_i),
      .dec_i(rep_dec), .cnt_o(rep_cnt_unused), .zero_o(rep_zero)
   );

   seq_gen_cnt #(.CW(GAP_W)) u_gap (
      .clk_i(ck_i), .rst_ni(r_i), .load_i(gap_load), .load_val_i(GAP_LOAD),
      .dec_i(gap_dec), .cnt_o(gap_cnt_unused), .zero_o(gap_zero)
   );

   // sout_d is the bit that will be visible on SOUT during the next cycle.
   always_comb begin
      state_d  = state_q;
      sout_d   = 1'b0;
      done_d   = 1'b0;
      cap      = 1'b0;
      idx_load = 1'b0;
      idx_val  = len_q;
      idx_dec  = 1'b0;
      rep_load = 1'b0;
      rep_dec  = 1'b0;
      gap_load = 1'b0;
      gap_dec  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (valid_i) begin
               cap      = 1'b1;
               state_d  = ST_SEND;
               idx_load = 1'b1;
               idx_val  = len_i;
               rep_load = 1'b1;
               sout_d   = din_i[len_i];
            end
         end
         ST_SEND: begin
            if (!idx_zero) begin
               idx_dec = 1'b1;
               sout_d  = data_q[idx_cnt - 3'd1];
            end else if (!rep_zero) begin
               rep_dec = 1'b1;
               if (GAP > 0) begin
                  state_d  = ST_GAP;
                  gap_load = 1'b1;
               end else begin
                  idx_load = 1'b1;
                  sout_d   = data_q[len_q];
               end
            end else begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_zero) begin
               state_d  = ST_SEND;
               idx_load = 1'b1;
               sout_d   = data_q[len_q];
            end else begin
               gap_dec = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ck_i) begin
      if (!r_i) begin
         state_q <= ST_IDLE;
         sout_q  <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         sout_q  <= sout_d;
         done_q  <= done_d;
         if (cap) begin
            data_q <= din_i;
            len_q  <= len_i;
         end
      end
   end

   assign ready_o = (state_q == ST_IDLE);
   assign busy_o  = (state_q != ST_IDLE);
   assign sout_o  = sout_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Randomized self-checking bench; DUT a has GAP=1, DUT b has GAP=0.
module tb_seq_gen;

   logic       ck = 1'b0;
   logic       r;
   logic [7:0] din;
   logic [2:0] len;
   logic [3:0] rep;
   logic       v_a, v_b;
   logic       rdy_a, so_a, bs_a, dn_a;
   logic       rdy_b, so_b, bs_b, dn_b;

   int n_tests = 0;
   int n_fail  = 0;
   bit exp_q[$];

   always #5 ck = ~ck;

   seq_gen #(.W(8), .GAP(1)) u_a (
      .ck_i(ck), .r_i(r), .din_i(din), .len_i(len), .rep_i(rep), .valid_i(v_a),
      .ready_o(rdy_a), .sout_o(so_a), .busy_o(bs_a), .done_o(dn_a)
   );

   seq_gen #(.W(8), .GAP(0)) u_b (
      .ck_i(ck), .r_i(r), .din_i(din), .len_i(len), .rep_i(rep), .valid_i(v_b),
      .ready_o(rdy_b), .sout_o(so_b), .busy_o(bs_b), .done_o(dn_b)
   );

   function automatic int gap_of(input bit sel);
      return sel ? 0 : 1;
   endfunction

   task automatic read(input bit sel, output logic s, output logic b, output logic rd, output logic dn);
      if (sel) begin
         s = so_b; b = bs_b; rd = rdy_b; dn = dn_b;
      end else begin
         s = so_a; b = bs_a; rd = rdy_a; dn = dn_a;
      end
   endtask

   // Reference stream: each repetition is the pattern MSB-first, separated by GAP zeros.
   task automatic build_exp(input bit sel, input logic [7:0] d, input logic [2:0] l, input logic [3:0] rp);
      exp_q.delete();
      for (int k = 0; k <= int'(rp); k++) begin
         for (int i = int'(l); i >= 0; i--) exp_q.push_back(d[i]);
         if (k < int'(rp))
            for (int g = 0; g < gap_of(sel); g++) exp_q.push_back(1'b0);
      end
   endtask

   // Entered at a negedge with the DUT ready; returns at the negedge of the DONE cycle.
   task automatic send_stream(input bit sel, input logic [7:0] d, input logic [2:0] l,
                              input logic [3:0] rp, input bit noise);
      logic s, b, rd, dn;
      build_exp(sel, d, l, rp);
      read(sel, s, b, rd, dn);
      n_tests++;
      if (rd !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_before_req dut%0d: got %b want 1", sel, rd);
      end
      din = d; len = l; rep = rp;
      v_a = !sel; v_b = sel;
      for (int k = 0; k < exp_q.size(); k++) begin
         @(negedge ck);
         read(sel, s, b, rd, dn);
         n_tests++;
         if (s !== exp_q[k]) begin
            n_fail++;
            $display("FAIL sout_bit%0d dut%0d: got %b want %b", k, sel, s, exp_q[k]);
         end
         n_tests++;
         if ({b, rd, dn} !== 3'b100) begin
            n_fail++;
            $display("FAIL busy_ready_done_cyc%0d dut%0d: got %b want 100", k, sel, {b, rd, dn});
         end
         din = noise ? 8'hFF : 8'($urandom);
         len = 3'($urandom);
         rep = 4'($urandom);
         if (noise) begin
            if (sel) v_b = 1'($urandom); else v_a = 1'($urandom);
         end else begin
            v_a = 1'b0; v_b = 1'b0;
         end
      end
      @(negedge ck);
      read(sel, s, b, rd, dn);
      n_tests++;
      if ({s, b, rd, dn} !== 4'b0011) begin
         n_fail++;
         $display("FAIL done_cycle dut%0d: sout/busy/ready/done got %b want 0011", sel, {s, b, rd, dn});
      end
      v_a = 1'b0; v_b = 1'b0;
   endtask

   task automatic check_idle(input bit sel, input string tag);
      logic s, b, rd, dn;
      @(negedge ck);
      read(sel, s, b, rd, dn);
      n_tests++;
      if ({s, b, rd, dn} !== 4'b0010) begin
         n_fail++;
         $display("FAIL idle_%s dut%0d: sout/busy/ready/done got %b want 0010", tag, sel, {s, b, rd, dn});
      end
   endtask

   task automatic test_reset();
      logic s, b, rd, dn;
      r = 1'b0; v_a = 1'b1; v_b = 1'b1; din = 8'hFF; len = 3'd7; rep = 4'd3;
      repeat (3) @(negedge ck);
      for (int sel = 0; sel < 2; sel++) begin
         read(sel[0], s, b, rd, dn);
         n_tests++;
         if ({s, b, rd, dn} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_state dut%0d: got %b want 0010", sel, {s, b, rd, dn});
         end
      end
      v_a = 1'b0; v_b = 1'b0;
      r = 1'b1;
      @(negedge ck);
   endtask

   task automatic test_basic();
      send_stream(1'b0, 8'h0B, 3'd3, 4'd0, 1'b0);
      check_idle(1'b0, "basic");
   endtask

   task automatic test_gap_repeat();
      send_stream(1'b0, 8'h0B, 3'd3, 4'd1, 1'b0);
      check_idle(1'b0, "gap_repeat");
   endtask

   task automatic test_no_gap();
      send_stream(1'b1, 8'hA5, 3'd7, 4'd2, 1'b0);
      check_idle(1'b1, "no_gap");
   endtask

   task automatic test_busy_reject();
      send_stream(1'b0, 8'h3C, 3'd5, 4'd2, 1'b1);
      check_idle(1'b0, "reject_a");
      send_stream(1'b1, 8'h81, 3'd7, 4'd1, 1'b1);
      check_idle(1'b1, "reject_b");
   endtask

   task automatic test_back_to_back();
      send_stream(1'b0, 8'h0B, 3'd3, 4'd0, 1'b0);
      send_stream(1'b0, 8'h06, 3'd2, 4'd1, 1'b0);
      check_idle(1'b0, "b2b_a");
      send_stream(1'b1, 8'hA5, 3'd7, 4'd0, 1'b0);
      send_stream(1'b1, 8'h01, 3'd0, 4'd2, 1'b0);
      check_idle(1'b1, "b2b_b");
   endtask

   task automatic test_reset_abort();
      logic s, b, rd, dn;
      build_exp(1'b0, 8'hC6, 3'd7, 4'd0);
      din = 8'hC6; len = 3'd7; rep = 4'd0; v_a = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge ck);
         v_a = 1'b0;
         read(1'b0, s, b, rd, dn);
         n_tests++;
         if (s !== exp_q[k]) begin
            n_fail++;
            $display("FAIL abort_pre_bit%0d: got %b want %b", k, s, exp_q[k]);
         end
      end
      r = 1'b0;
      @(negedge ck);
      read(1'b0, s, b, rd, dn);
      n_tests++;
      if ({s, b, rd, dn} !== 4'b0010) begin
         n_fail++;
         $display("FAIL abort_state: sout/busy/ready/done got %b want 0010", {s, b, rd, dn});
      end
      r = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge ck);
         read(1'b0, s, b, rd, dn);
         n_tests++;
         if ({b, dn} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_no_done cyc%0d: busy/done got %b want 00", k, {b, dn});
         end
      end
      r = 1'b0;
      @(negedge ck);
      r = 1'b1;
      send_stream(1'b0, 8'h96, 3'd7, 4'd1, 1'b0);
      check_idle(1'b0, "after_reset");
   endtask

   task automatic test_random();
      bit sel, noise, b2b;
      b2b = 1'b0;
      for (int n = 0; n < 24; n++) begin
         if (!b2b) sel = 1'($urandom);
         noise = 1'($urandom);
         send_stream(sel, 8'($urandom), 3'($urandom), 4'($urandom_range(0, 5)), noise);
         b2b = 1'($urandom);
         if (!b2b) check_idle(sel, "random");
      end
      if (b2b) check_idle(sel, "random_end");
   endtask

   initial begin
      r = 1'b0; v_a = 1'b0; v_b = 1'b0; din = '0; len = '0; rep = '0;
      @(negedge ck);
      test_reset();
      test_basic();
      test_gap_repeat();
      test_no_gap();
      test_busy_reject();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter: W, 8, pattern register width in bits.
REQ-002 Parameter: GAP, 1, idle-low cycles inserted between repetitions; 0 to 15 legal.
REQ-003 CK  input  1  single clock; all state changes on rising edge.
REQ-004 R  input  1  reset, synchronous, active-low.
REQ-005 DIN  input  W  pattern to serialize; bit DIN[LEN] is sent first, down to DIN[0].
REQ-006 LEN  input  3  bits per repetition minus one (1..8 bits).
REQ-007 REP  input  4  repetitions minus one (1..16 repetitions).
REQ-008 VALID  input  1  request strobe; DIN/LEN/REP are valid while high.
REQ-009 READY  output  1  high when a request can be accepted.
REQ-010 SOUT  output  1  serial bit stream, registered.
REQ-011 BUSY  output  1  high while sending or in a gap.
REQ-012 DONE  output  1  one-cycle pulse after the final bit of the final repetition.

Function
REQ-013 The FSM SHALL have states IDLE, SEND and GAP.
REQ-014 READY SHALL equal (state == IDLE), combinationally from registered state.
REQ-015 Acceptance: VALID && READY at a rising edge latches DIN, LEN and REP, then enters SEND.
REQ-016 First bit: DIN[LEN] SHALL appear on SOUT in the first cycle after acceptance (latency 1).
REQ-017 SEND: SOUT SHALL output one bit per cycle, MSB-first from index LEN down to 0.
REQ-018 After index 0, remaining repetitions > 0 and GAP > 0: enter GAP.
REQ-019 After index 0, remaining repetitions > 0 and GAP = 0: restart at index LEN with no idle cycle.
REQ-020 After index 0, no repetitions remain: enter IDLE.
REQ-021 GAP: SOUT SHALL be 0 for exactly GAP cycles, then return to SEND at index LEN.
REQ-022 DONE SHALL be high only in the first IDLE cycle after the final bit.
REQ-023 READY SHALL be high in the DONE cycle, and a request accepted then starts immediately, giving back-to-back streams.
REQ-024 In IDLE, SOUT SHALL be 0 and BUSY SHALL be 0.
REQ-025 BUSY SHALL be 1 in SEND and GAP.
REQ-026 VALID while BUSY SHALL be ignored; no capture and no queuing.
REQ-027 DIN/LEN/REP changes after acceptance SHALL NOT affect the stream in progress.
REQ-028 Counters: bit index 3 bits and repetition counter 4 bits, decrementing.
REQ-029 Counters SHALL never wrap.
REQ-030 Total stream length SHALL be (LEN+1)*(REP+1) + GAP*REP cycles.

Reset
REQ-031 While R = 0 at a rising edge: state := IDLE, SOUT := 0, BUSY := 0, DONE := 0, counters := 0.
REQ-032 Reset mid-SEND or mid-GAP SHALL abort the stream without a DONE pulse.
REQ-033 After reset, the first VALID accepted on the first edge with R = 1 SHALL start normally.

Structure
REQ-034 Package seq_gen_pkg SHALL hold the state enum (IDLE/SEND/GAP), W default and counter width constants.
REQ-035 One sub-module is natural: seq_gen_cnt, a loadable down-counter with zero flag, used for the bit index, repetitions and gap.
REQ-036 The output stream SHALL be directly consumable by the team's Moore sequence detector (IN <- SOUT, same CK).

Verification
REQ-037 Basic: DIN=8'h0B, LEN=3, REP=0 -> SOUT 1,0,1,1 in cycles 1-4 after accept; DONE in cycle 5.
REQ-038 Repeat with gap: DIN=8'h0B, LEN=3, REP=1, GAP=1 -> SOUT 1,0,1,1,0,1,0,1,1; DONE once, after the ninth bit.
REQ-039 Repeat, no gap: GAP=0, DIN=8'hA5, LEN=7, REP=2 -> 24 bits 10100101 x3, BUSY high 24 cycles.
REQ-040 Busy reject: VALID pulsed with DIN=8'hFF during SEND -> stream unchanged, no extra transfer.
REQ-041 Back-to-back: VALID held high with two requests -> second stream's first bit in the cycle after DONE.
REQ-042 Reset abort: R low at bit 2 of an 8-bit send -> next cycle SOUT=0, BUSY=0, READY=1, DONE never pulses.
